// File: rtl/dcache_mem_bridge_if.sv
// Bundle of dcache refill/writeback signals and the single-word SRAM bus seen by the bridge.
// slave: the bridge's view. master: the dcache/memory environment's view.
interface dcache_mem_bridge_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();
    logic            ram_rd_req_i;
    logic [AW-1:0]   ram_rd_addr_i;
    logic            ram_rd_rdy_o;
    logic [DW-1:0]   ram_rd_data_o;
    logic [2:0]      ram_rd_num_o;
    logic            ram_wr_req_i;
    logic [AW-1:0]   ram_wr_addr_i;
    logic [4*DW-1:0] ram_wr_data_i;
    logic            ram_dirty_i;
    logic            ram_wr_rdy_o;
    logic            mem_req_o;
    logic            mem_we_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_wdata_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [DW-1:0]   mem_rdata_i;

    modport slave (
        input  ram_rd_req_i, ram_rd_addr_i, ram_wr_req_i, ram_wr_addr_i, ram_wr_data_i,
               ram_dirty_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output ram_rd_rdy_o, ram_rd_data_o, ram_rd_num_o, ram_wr_rdy_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output ram_rd_req_i, ram_rd_addr_i, ram_wr_req_i, ram_wr_addr_i, ram_wr_data_i,
               ram_dirty_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  ram_rd_rdy_o, ram_rd_data_o, ram_rd_num_o, ram_wr_rdy_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/dcache_mem_bridge.sv
// Memory-side responder for dcache line refills (4 beats) and dirty writebacks, one SRAM access at a time.
// Optional macro DCACHE_CRITICAL_WORD_FIRST_EN: refill starts at ram_rd_addr_i[3:2] and wraps modulo 4.
module dcache_mem_bridge #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input logic           clk,
    input logic           rst_n,
    dcache_mem_bridge_if.slave bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WB_REQ  = 3'd1;
    localparam logic [2:0] WB_DONE = 3'd2;
    localparam logic [2:0] RD_REQ  = 3'd3;
    localparam logic [2:0] RD_WAIT = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [AW-1:0]   base_q, base_d;
    logic [4*DW-1:0] line_q, line_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            rd_rdy_q, rd_rdy_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic [2:0]      rd_num_q, rd_num_d;
    logic            wr_rdy_q, wr_rdy_d;
    logic [1:0]      start_idx;

`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
    assign start_idx = bus.ram_rd_addr_i[3:2];
`else
    assign start_idx = 2'd0;
`endif

    // Line-offset bits are don't-care; the line base is rebuilt from [AW-1:4].
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.ram_rd_addr_i[3:0], bus.ram_wr_addr_i[3:0]};

    // State and registered outputs; reset aborts any transaction at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            base_q      <= '0;
            line_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_rdy_q    <= 1'b0;
            rd_data_q   <= '0;
            rd_num_q    <= '0;
            wr_rdy_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            line_q      <= line_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_rdy_q    <= rd_rdy_d;
            rd_data_q   <= rd_data_d;
            rd_num_q    <= rd_num_d;
            wr_rdy_q    <= wr_rdy_d;
        end
    end

    // Next state plus the values the output registers take on the coming edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        base_d      = base_q;
        line_d      = line_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_rdy_d    = 1'b0;
        rd_data_d   = rd_data_q;
        rd_num_d    = rd_num_q;
        wr_rdy_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.ram_wr_req_i && bus.ram_dirty_i) begin
                    base_d      = {bus.ram_wr_addr_i[AW-1:4], 4'b0000};
                    line_d      = bus.ram_wr_data_i;
                    cnt_d       = 2'd0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {bus.ram_wr_addr_i[AW-1:4], 4'b0000};
                    mem_wdata_d = bus.ram_wr_data_i[DW-1:0];
                    state_d     = WB_REQ;
                end else if (bus.ram_rd_req_i) begin
                    base_d     = {bus.ram_rd_addr_i[AW-1:4], 4'b0000};
                    idx_d      = start_idx;
                    cnt_d      = 2'd0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {bus.ram_rd_addr_i[AW-1:4], start_idx, 2'b00};
                    state_d    = RD_REQ;
                end
            end
            WB_REQ: begin
                if (bus.mem_gnt_i) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        wr_rdy_d  = 1'b1;
                        state_d   = WB_DONE;
                    end else begin
                        mem_addr_d  = {base_q[AW-1:4], cnt_d, 2'b00};
                        mem_wdata_d = DW'(line_q >> (32'(cnt_d) * DW));
                    end
                end
            end
            WB_DONE: begin
                state_d = IDLE;
            end
            RD_REQ: begin
                if (bus.mem_gnt_i) begin
                    mem_req_d = 1'b0;
                    state_d   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus.mem_rvalid_i) begin
                    rd_rdy_d  = 1'b1;
                    rd_data_d = bus.mem_rdata_i;
                    rd_num_d  = {1'b0, idx_q};
                    cnt_d     = cnt_q + 2'd1;
                    idx_d     = idx_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = IDLE;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = {base_q[AW-1:4], idx_d, 2'b00};
                        state_d    = RD_REQ;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    assign bus.mem_req_o     = mem_req_q;
    assign bus.mem_we_o      = mem_we_q;
    assign bus.mem_addr_o    = mem_addr_q;
    assign bus.mem_wdata_o   = mem_wdata_q;
    assign bus.ram_rd_rdy_o  = rd_rdy_q;
    assign bus.ram_rd_data_o = rd_data_q;
    assign bus.ram_rd_num_o  = rd_num_q;
    assign bus.ram_wr_rdy_o  = wr_rdy_q;
endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Scoreboard bench for dcache_mem_bridge: expected memory accesses, beats and writeback strobes are queued
// at issue time and checked by the memory model and an output monitor.
module tb_dcache_mem_bridge;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dcache_mem_bridge_if #(.AW(AW), .DW(DW)) bus ();
    dcache_mem_bridge #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } acc_t;
    typedef struct { logic [2:0] num; logic [31:0] data; } beat_t;

    acc_t  acc_q[$];
    beat_t beat_q[$];
    int    wr_rdy_exp = 0;
    int    beats_seen = 0;
    int    checks = 0;
    int    failures = 0;
    int    gnt_delay = 0;
    logic [31:0] pat = 32'h0;
    logic  stray = 1'b0;

`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Memory model: grants after gnt_delay waiting cycles, returns read data the cycle after grant.
    initial begin : mem_model
        int   wait_cnt;
        logic rd_pend;
        logic [31:0] rd_addr;
        acc_t a;
        wait_cnt = 0;
        rd_pend  = 1'b0;
        rd_addr  = '0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        forever begin
            @(posedge clk); #1;
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = 1'b0;
            if (!rst_n) begin
                rd_pend  = 1'b0;
                wait_cnt = 0;
            end else begin
                if (rd_pend) begin
                    bus.mem_rvalid_i = 1'b1;
                    bus.mem_rdata_i  = pat + 32'(rd_addr[3:2]);
                    rd_pend = 1'b0;
                end else if (stray) begin
                    bus.mem_rvalid_i = 1'b1;
                    bus.mem_rdata_i  = 32'hDEAD_BEEF;
                    stray = 1'b0;
                end
                if (bus.mem_req_o) begin
                    if (acc_q.size() == 0) begin
                        fail_now("mem_req_unexpected");
                    end else if (wait_cnt < gnt_delay) begin
                        wait_cnt++;
                        check("mem_addr_stable", bus.mem_addr_o, acc_q[0].addr);
                        if (acc_q[0].we) check("mem_wdata_stable", bus.mem_wdata_o, acc_q[0].wdata);
                    end else begin
                        bus.mem_gnt_i = 1'b1;
                        wait_cnt = 0;
                        a = acc_q.pop_front();
                        check("mem_we", 32'(bus.mem_we_o), 32'(a.we));
                        check("mem_addr", bus.mem_addr_o, a.addr);
                        if (a.we) begin
                            check("mem_wdata", bus.mem_wdata_o, a.wdata);
                        end else begin
                            check("rd_before_wr_rdy", 32'(wr_rdy_exp), 32'd0);
                            rd_pend = 1'b1;
                            rd_addr = bus.mem_addr_o;
                        end
                    end
                end
            end
        end
    end

    // Output monitor: pops the beat queue on every ram_rd_rdy_o and the strobe count on ram_wr_rdy_o.
    initial begin : monitor
        beat_t b;
        forever begin
            @(posedge clk); #1;
            if (bus.ram_rd_rdy_o) begin
                beats_seen++;
                if (beat_q.size() == 0) begin
                    fail_now("beat_unexpected");
                end else begin
                    b = beat_q.pop_front();
                    check("beat_num", 32'(bus.ram_rd_num_o), 32'(b.num));
                    check("beat_data", bus.ram_rd_data_o, b.data);
                end
            end
            if (bus.ram_wr_rdy_o) begin
                if (wr_rdy_exp == 0) begin
                    fail_now("wr_rdy_unexpected");
                end else begin
                    checks++;
                    wr_rdy_exp--;
                end
            end
        end
    end

    task automatic issue_refill(input logic [31:0] addr, input logic [31:0] p);
        logic [1:0] idx;
        acc_t  a;
        beat_t b;
        idx = CWF ? addr[3:2] : 2'd0;
        pat = p;
        for (int i = 0; i < 4; i++) begin
            a.we = 1'b0; a.addr = {addr[31:4], idx, 2'b00}; a.wdata = '0;
            acc_q.push_back(a);
            b.num = {1'b0, idx}; b.data = p + 32'(idx);
            beat_q.push_back(b);
            idx = idx + 2'd1;
        end
        bus.ram_rd_addr_i = addr;
        bus.ram_rd_req_i  = 1'b1;
    endtask

    task automatic issue_wb(input logic [31:0] addr, input logic [127:0] data);
        acc_t a;
        for (int i = 0; i < 4; i++) begin
            a.we = 1'b1; a.addr = {addr[31:4], 4'h0} + 32'(4 * i); a.wdata = data[32*i +: 32];
            acc_q.push_back(a);
        end
        wr_rdy_exp++;
        bus.ram_wr_addr_i = addr;
        bus.ram_wr_data_i = data;
        bus.ram_dirty_i   = 1'b1;
        bus.ram_wr_req_i  = 1'b1;
    endtask

    // Acts as the dcache: drops each request on its response, until all expectations drain.
    task automatic run(input int budget);
        int n;
        n = 0;
        while (!(acc_q.size() == 0 && beat_q.size() == 0 && wr_rdy_exp == 0 && !bus.mem_req_o)) begin
            @(posedge clk); #2;
            if (bus.ram_rd_rdy_o) bus.ram_rd_req_i = 1'b0;
            if (bus.ram_wr_rdy_o) begin bus.ram_wr_req_i = 1'b0; bus.ram_dirty_i = 1'b0; end
            n++;
            if (n > budget) begin
                $display("FAIL run_timeout pending_acc=%0d pending_beats=%0d pending_wr=%0d",
                         acc_q.size(), beat_q.size(), wr_rdy_exp);
                acc_q.delete(); beat_q.delete(); wr_rdy_exp = 0;
                failures++;
                break;
            end
        end
        checks++;
        bus.ram_rd_req_i = 1'b0;
        bus.ram_wr_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin : main
        int seen;
        logic [1:0] last;
        rst_n = 1'b0;
        bus.ram_rd_req_i = 1'b0; bus.ram_rd_addr_i = '0;
        bus.ram_wr_req_i = 1'b0; bus.ram_wr_addr_i = '0;
        bus.ram_wr_data_i = '0;  bus.ram_dirty_i = 1'b0;
        #3;
        check("rst_mem_req", 32'(bus.mem_req_o), 0);
        check("rst_mem_we", 32'(bus.mem_we_o), 0);
        check("rst_mem_addr", bus.mem_addr_o, 0);
        check("rst_mem_wdata", bus.mem_wdata_o, 0);
        check("rst_rd_rdy", 32'(bus.ram_rd_rdy_o), 0);
        check("rst_rd_data", bus.ram_rd_data_o, 0);
        check("rst_rd_num", 32'(bus.ram_rd_num_o), 0);
        check("rst_wr_rdy", 32'(bus.ram_wr_rdy_o), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;

        // Zero-wait refill at 0x1004.
        gnt_delay = 0;
        issue_refill(32'h0000_1004, 32'hA000_0000);
        run(100);
        last = (CWF ? 2'd1 : 2'd0) + 2'd3;
        check("rd_data_hold", bus.ram_rd_data_o, 32'hA000_0000 + 32'(last));

        // Writeback with two-cycle grant delay on every word.
        gnt_delay = 2;
        issue_wb(32'h0000_2000, {32'h33, 32'h22, 32'h11, 32'h00});
        run(100);

        // Simultaneous requests: writeback first, refill after.
        gnt_delay = 1;
        issue_wb(32'h0000_3000, {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000});
        issue_refill(32'h0000_3008, 32'hB000_0000);
        run(200);

        // Clean writeback request is ignored.
        gnt_delay = 0;
        bus.ram_wr_addr_i = 32'h0000_6000;
        bus.ram_wr_data_i = {4{32'h5555_AAAA}};
        bus.ram_dirty_i   = 1'b0;
        bus.ram_wr_req_i  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            check("clean_mem_req", 32'(bus.mem_req_o), 0);
            check("clean_wr_rdy", 32'(bus.ram_wr_rdy_o), 0);
        end
        bus.ram_wr_req_i = 1'b0;
        @(posedge clk); #2;

        // Line at the top of the address space wraps within the line.
        issue_refill(32'hFFFF_FFF8, 32'hE000_0000);
        run(100);

        // Reset after the second beat aborts the refill.
        seen = beats_seen;
        issue_refill(32'h0000_4000, 32'hC000_0000);
        for (int i = 0; i < 100 && beats_seen < seen + 2; i++) begin
            @(posedge clk); #2;
            if (bus.ram_rd_rdy_o) bus.ram_rd_req_i = 1'b0;
        end
        check("abort_two_beats", 32'(beats_seen - seen), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("abort_mem_req", 32'(bus.mem_req_o), 0);
        check("abort_rd_rdy", 32'(bus.ram_rd_rdy_o), 0);
        check("abort_rd_data", bus.ram_rd_data_o, 0);
        check("abort_mem_addr", bus.mem_addr_o, 0);
        acc_q.delete(); beat_q.delete();
        bus.ram_rd_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #2 stray = 1'b1;
        seen = beats_seen;
        repeat (6) @(posedge clk);
        #2;
        check("stray_rvalid_beats", 32'(beats_seen - seen), 0);
        check("stray_mem_req", 32'(bus.mem_req_o), 0);
        issue_refill(32'h0000_5004, 32'hD000_0000);
        run(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
